fifo_wr_ctrl: RTL and testbench

Write-side pointer and full-flag controller for the async dual-clock FIFO; the counterpart of the read-side controller in the read clock domain.
- Keeps the binary write pointer and drives the memory write address and write strobe.
- Publishes a Gray-coded write pointer to the read domain.
- Synchronises the read side's Gray pointer into w_clk and derives w_full and a fill level from it.

---
 rtl/fifo_pkg.sv | 34 +++
 rtl/fifo_ptr_sync.sv | 32 +++
 rtl/fifo_wr_ctrl.sv | 77 +++++++
 tb/tb_fifo_wr_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: Gray-code helpers and defaults shared by the async FIFO
// write-side and read-side pointer controllers.
package fifo_pkg;

   localparam int FIFO_SYNC_STAGES = 2;

   // Widest pointer the helpers handle; callers zero-extend and truncate.
   localparam int PTR_W_MAX = 16;

   typedef logic [PTR_W_MAX-1:0] ptr_t;

   function automatic ptr_t bin2gray(input ptr_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic ptr_t gray2bin(input ptr_t g);
      ptr_t b;
      b[PTR_W_MAX-1] = g[PTR_W_MAX-1];
      for (int i = PTR_W_MAX-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Full: pointers match except the two MSBs of the aw+1 bit Gray code.
   function automatic logic gray_full(input ptr_t gw,
                                      input ptr_t gr,
                                      input int   aw);
      ptr_t flip;
      flip = ptr_t'(2'b11) << (aw - 1);
      return gw == (gr ^ flip);
   endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync: plain flop chain carrying a Gray pointer across
// clock domains, async active-low reset.
module fifo_ptr_sync
   import fifo_pkg::*;
#(
   parameter int W      = 4,
   parameter int STAGES = FIFO_SYNC_STAGES
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] rq_q [STAGES];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < STAGES; i++) begin
            rq_q[i] <= '0;
         end
      end else begin
         rq_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            rq_q[i] <= rq_q[i-1];
         end
      end
   end

   assign q_o = rq_q[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl: async FIFO write pointer, Gray publish, full and level.
// Optional w_almost_full output enabled by WR_ALMOST_FULL_EN.
module fifo_wr_ctrl
   import fifo_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = FIFO_SYNC_STAGES,
   parameter int AF_THRESH   = DEPTH - 2,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic          w_clk,
   input  logic          w_rst,
   input  logic          w_inc,
   input  logic [AW:0]   gray_r_ptr,
   output logic          w_en,
   output logic [AW-1:0] w_addr,
   output logic [AW:0]   gray_w_ptr,
   output logic          w_full,
   output logic [AW:0]   w_level
`ifdef WR_ALMOST_FULL_EN
   ,
   output logic          w_almost_full
`endif
);

   logic [AW:0] w_ptr_q;
   logic [AW:0] w_ptr_d;
   logic [AW:0] gray_q;
   logic [AW:0] gray_d;
   logic [AW:0] rq_s;
   logic [AW:0] rbin;

   fifo_ptr_sync #(
      .W      (AW + 1),
      .STAGES (SYNC_STAGES)
   ) u_rsync (
      .clk_i  (w_clk),
      .rst_ni (w_rst),
      .d_i    (gray_r_ptr),
      .q_o    (rq_s)
   );

   assign w_en = w_inc && !w_full;

   always_comb begin
      w_ptr_d = w_ptr_q;
      if (w_en) begin
         w_ptr_d = w_ptr_q + (AW+1)'(1);
      end
   end

   // Gray register tracks the next binary value so it never lags w_ptr.
   assign gray_d = (AW+1)'(bin2gray(ptr_t'(w_ptr_d)));

   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         w_ptr_q <= '0;
         gray_q  <= '0;
      end else begin
         w_ptr_q <= w_ptr_d;
         gray_q  <= gray_d;
      end
   end

   assign w_addr     = w_ptr_q[AW-1:0];
   assign gray_w_ptr = gray_q;

   assign w_full = gray_full(ptr_t'(gray_q), ptr_t'(rq_s), AW);

   assign rbin    = (AW+1)'(gray2bin(ptr_t'(rq_s)));
   assign w_level = w_ptr_q - rbin;

`ifdef WR_ALMOST_FULL_EN
   assign w_almost_full = (w_level >= (AW+1)'(AF_THRESH));
`endif

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl: scoreboard bench for the FIFO write-side controller.
// A second instance with SYNC_STAGES=3 covers synchroniser latency.
`timescale 1ns/1ps
module tb_fifo_wr_ctrl;

   localparam int DEPTH = 8;
   localparam int AW    = 3;
   localparam int S2    = 2;
   localparam int S3    = 3;

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b1;
   logic          w_inc  = 1'b0;
   logic          w_inc3 = 1'b0;
   logic [AW:0]   gray_r = '0;

   logic          w_en, w_full, w_en3, w_full3;
   logic [AW-1:0] w_addr, w_addr3;
   logic [AW:0]   gray_w, w_level, gray_w3, w_level3;
`ifdef WR_ALMOST_FULL_EN
   logic          w_af, w_af3;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fifo_wr_ctrl #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (S2),
      .AF_THRESH   (6)
   ) dut (
      .w_clk         (clk),
      .w_rst         (rst_n),
      .w_inc         (w_inc),
      .gray_r_ptr    (gray_r),
      .w_en          (w_en),
      .w_addr        (w_addr),
      .gray_w_ptr    (gray_w),
      .w_full        (w_full),
      .w_level       (w_level)
`ifdef WR_ALMOST_FULL_EN
      ,
      .w_almost_full (w_af)
`endif
   );

   fifo_wr_ctrl #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (S3),
      .AF_THRESH   (6)
   ) dut3 (
      .w_clk         (clk),
      .w_rst         (rst_n),
      .w_inc         (w_inc3),
      .gray_r_ptr    (gray_r),
      .w_en          (w_en3),
      .w_addr        (w_addr3),
      .gray_w_ptr    (gray_w3),
      .w_full        (w_full3),
      .w_level       (w_level3)
`ifdef WR_ALMOST_FULL_EN
      ,
      .w_almost_full (w_af3)
`endif
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [AW:0]   gray;
      logic          full;
      logic [AW:0]   level;
   } exp_t;

   exp_t        sbq[$];
   logic [AW:0] lq[$];
   logic [AW:0] lq3[$];

   // Reference model: binary write count and history of sampled read ptrs.
   logic [AW:0] m_wp;
   logic [AW:0] m_rh[$];

   function automatic logic [AW:0] g_of(input logic [AW:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [AW:0] b_of(input logic [AW:0] g);
      logic [AW:0] b;
      b[AW] = g[AW];
      for (int i = AW-1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   function automatic logic [AW:0] m_level();
      return m_wp - b_of(m_rh[0]);
   endfunction

   task automatic model_reset();
      m_wp = '0;
      m_rh.delete();
      for (int i = 0; i < S2; i++) m_rh.push_back('0);
   endtask

   task automatic tick();
      exp_t e;
      logic acc;
      acc = w_inc && (m_level() != (AW+1)'(DEPTH));
      m_rh.push_back(gray_r);
      void'(m_rh.pop_front());
      if (acc) m_wp = (AW+1)'(m_wp + 1);
      e.addr  = m_wp[AW-1:0];
      e.gray  = g_of(m_wp);
      e.level = m_level();
      e.full  = (e.level == (AW+1)'(DEPTH));
      sbq.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t e;
      w_inc = 1'b1;
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (w_addr !== 0 || gray_w !== 0 || w_full !== 0 ||
          w_level !== 0 || w_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_init addr=%0d gray=%b full=%b lvl=%0d en=%b",
                  w_addr, gray_w, w_full, w_level, w_en);
      end
`ifdef WR_ALMOST_FULL_EN
      checks++;
      if (w_af !== 1'b0) begin
         errors++;
         $display("FAIL reset_af got=%b want=0", w_af);
      end
`endif
      rst_n = 1'b1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         tick();
         e = sbq.pop_front();
         checks++;
         if (w_addr !== e.addr || gray_w !== e.gray ||
             w_full !== e.full || w_level !== e.level) begin
            errors++;
            $display("FAIL reset_wr%0d addr=%0d/%0d gray=%b/%b lvl=%0d/%0d",
                     k, w_addr, e.addr, gray_w, e.gray, w_level, e.level);
         end
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (w_addr !== 0 || gray_w !== 0 || w_full !== 0 ||
          w_level !== 0 || w_en !== w_inc) begin
         errors++;
         $display("FAIL reset_mid addr=%0d gray=%b full=%b lvl=%0d en=%b",
                  w_addr, gray_w, w_full, w_level, w_en);
      end
      #1 rst_n = 1'b1;
      w_inc = 1'b0;
      model_reset();
   endtask

   task automatic test_fill();
      exp_t e;
      gray_r = '0;
      w_inc  = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         checks++;
         if (w_addr !== 3'(k <= 8 ? k-1 : 0) || w_en !== (k <= 8)) begin
            errors++;
            $display("FAIL fill_pre%0d addr=%0d en=%b", k, w_addr, w_en);
         end
         tick();
         e = sbq.pop_front();
         checks++;
         if (w_addr !== e.addr || gray_w !== e.gray ||
             w_full !== e.full || w_level !== e.level) begin
            errors++;
            $display("FAIL fill_e%0d addr=%0d/%0d gray=%b/%b full=%b/%b lvl=%0d/%0d",
                     k, w_addr, e.addr, gray_w, e.gray,
                     w_full, e.full, w_level, e.level);
         end
         if (k >= 8) begin
            checks++;
            if (gray_w !== 4'b1100 || w_full !== 1'b1 || w_level !== 4'd8) begin
               errors++;
               $display("FAIL fill_full%0d gray=%b full=%b lvl=%0d",
                        k, gray_w, w_full, w_level);
            end
         end
      end
      w_inc = 1'b0;
   endtask

   task automatic test_release();
      exp_t e;
      gray_r = 4'b0001;
      tick();
      e = sbq.pop_front();
      checks++;
      if (w_full !== 1'b1 || w_full !== e.full || w_level !== e.level) begin
         errors++;
         $display("FAIL rel_e1 full=%b want=1 lvl=%0d/%0d", w_full, w_level, e.level);
      end
      tick();
      e = sbq.pop_front();
      checks++;
      if (w_full !== 1'b0 || w_level !== 4'd7 || w_level !== e.level) begin
         errors++;
         $display("FAIL rel_e2 full=%b want=0 lvl=%0d want=7", w_full, w_level);
      end
      w_inc = 1'b1;
      #1;
      checks++;
      if (w_en !== 1'b1) begin
         errors++;
         $display("FAIL rel_en got=%b want=1", w_en);
      end
      tick();
      e = sbq.pop_front();
      checks++;
      if (w_full !== 1'b1 || gray_w !== 4'b1101 || gray_w !== e.gray) begin
         errors++;
         $display("FAIL rel_refill full=%b gray=%b want=1101", w_full, gray_w);
      end
      w_inc = 1'b0;
   endtask

   task automatic test_wrap();
      exp_t        e;
      logic [AW:0] pg;
      logic [AW-1:0] pa;
      bit          gwrap = 0;
      bit          awrap = 0;
      gray_r = g_of(m_wp);
      for (int k = 0; k < 2; k++) begin
         tick();
         void'(sbq.pop_front());
      end
      w_inc = 1'b1;
      for (int k = 0; k < 20; k++) begin
         pg = gray_w;
         pa = w_addr;
         gray_r = g_of(m_wp);
         tick();
         e = sbq.pop_front();
         checks++;
         if (w_addr !== e.addr || gray_w !== e.gray || w_full !== 1'b0 ||
             w_level !== e.level || w_level > 4'd2) begin
            errors++;
            $display("FAIL wrap%0d addr=%0d/%0d gray=%b/%b full=%b lvl=%0d/%0d",
                     k, w_addr, e.addr, gray_w, e.gray,
                     w_full, w_level, e.level);
         end
         if (pg == 4'b1000 && gray_w == 4'b0000) gwrap = 1;
         if (pa == 3'd7 && w_addr == 3'd0) awrap = 1;
      end
      w_inc = 1'b0;
      checks++;
      if (!gwrap || !awrap) begin
         errors++;
         $display("FAIL wrap_seen gray=%0d addr=%0d want=1/1", gwrap, awrap);
      end
   endtask

   task automatic test_sync_latency();
      exp_t e;
      logic [AW:0] lv, lv3;
      gray_r = '0;
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      w_inc  = 1'b1;
      w_inc3 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         e = sbq.pop_front();
         checks++;
         if (w_level !== e.level || w_addr3 !== e.addr || w_level3 !== e.level) begin
            errors++;
            $display("FAIL lat_fill%0d lvl=%0d lvl3=%0d want=%0d",
                     k, w_level, w_level3, e.level);
         end
      end
      w_inc  = 1'b0;
      w_inc3 = 1'b0;
      for (int t = 0; t < 2; t++) begin
         #3;
         gray_r = (t == 0) ? 4'b0010 : 4'b0000;
         for (int k = 1; k <= 4; k++) begin
            lq.push_back((k >= S2) ? ((t == 0) ? 4'd1 : 4'd4)
                                   : ((t == 0) ? 4'd4 : 4'd1));
            lq3.push_back((k >= S3) ? ((t == 0) ? 4'd1 : 4'd4)
                                    : ((t == 0) ? 4'd4 : 4'd1));
         end
         for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            lv  = lq.pop_front();
            lv3 = lq3.pop_front();
            checks++;
            if (w_level !== lv || w_level3 !== lv3) begin
               errors++;
               $display("FAIL lat_t%0d_e%0d lvl=%0d/%0d lvl3=%0d/%0d",
                        t, k, w_level, lv, w_level3, lv3);
            end
         end
      end
   endtask

`ifdef WR_ALMOST_FULL_EN
   task automatic test_almost_full();
      exp_t e;
      gray_r = '0;
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      model_reset();
      w_inc = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         e = sbq.pop_front();
         checks++;
         if (w_af !== (k >= 6) || w_level !== e.level) begin
            errors++;
            $display("FAIL af_e%0d af=%b want=%b lvl=%0d/%0d",
                     k, w_af, (k >= 6), w_level, e.level);
         end
      end
      w_inc = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_fill();
      test_release();
      test_wrap();
      test_sync_latency();
`ifdef WR_ALMOST_FULL_EN
      test_almost_full();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
